router_input_port: RTL

Per-input-port front end of the 8x8 router. It deserializes one serial input lane: a frame_n/valid_n framed packet with a 4-bit destination address, variable padding and a 32-bit payload. It checks the framing protocol and presents each complete packet as a parallel word to the switch fabric over a valid/ready handshake. The router contains eight instances, one per input lane.

---
 rtl/router_input_port.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/router_input_port.sv
// Input-lane front end: deserializes one framed serial lane, checks the framing
// and hands each complete packet to the fabric through a valid/ready holding register.
module router_input_port #(
    parameter int PAD_MAX   = 15,
    parameter int DATA_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_n,
    input  logic                 valid_n,
    input  logic                 di,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [3:0]           pkt_da,
    output logic [DATA_BITS-1:0] pkt_data,
    output logic                 err_proto,
    output logic                 err_drop,
    output logic [7:0]           pkt_cnt
);

    localparam int PAD_W = $clog2(PAD_MAX + 2);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [PAD_W-1:0] PAD_LIMIT = PAD_W'(PAD_MAX);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PAD,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [1:0]           addr_cnt;
    logic [1:0]           addr_cnt_next;
    logic [PAD_W-1:0]     pad_cnt;
    logic [PAD_W-1:0]     pad_cnt_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_next;
    logic [3:0]           da_sh;
    logic [3:0]           da_sh_next;
    logic [DATA_BITS-2:0] data_sh;
    logic [DATA_BITS-2:0] data_sh_next;
    logic [DATA_BITS-2:0] data_shifted;
    logic [DATA_BITS-1:0] assembled;
    logic                 proto_det;
    logic                 complete;

    // Payload arrives LSB first: shift in at the top so bit 0 ends at position 0;
    // the final bit is appended directly so the load happens on the completion edge.
    assign data_shifted = {di, data_sh[DATA_BITS-2:1]};
    assign assembled    = {di, data_sh};

    always_comb begin
        state_next    = state;
        addr_cnt_next = addr_cnt;
        pad_cnt_next  = pad_cnt;
        bit_cnt_next  = bit_cnt;
        da_sh_next    = da_sh;
        data_sh_next  = data_sh;
        proto_det     = 1'b0;
        complete      = 1'b0;

        case (state)
            S_IDLE: begin
                if (!frame_n) begin
                    if (valid_n) begin
                        da_sh_next    = {3'b000, di};
                        addr_cnt_next = 2'd1;
                        state_next    = S_ADDR;
                    end else begin
                        proto_det  = 1'b1;
                        state_next = S_DRAIN;
                    end
                end
            end

            S_ADDR: begin
                if (frame_n) begin
                    proto_det  = 1'b1;
                    state_next = S_IDLE;
                end else if (!valid_n) begin
                    proto_det  = 1'b1;
                    state_next = S_DRAIN;
                end else begin
                    da_sh_next[addr_cnt] = di;
                    addr_cnt_next        = addr_cnt + 2'd1;
                    if (addr_cnt == 2'd3) begin
                        pad_cnt_next = '0;
                        state_next   = S_PAD;
                    end
                end
            end

            S_PAD: begin
                if (frame_n) begin
                    proto_det  = 1'b1;
                    state_next = S_IDLE;
                end else if (valid_n) begin
                    if (pad_cnt == PAD_LIMIT) begin
                        proto_det  = 1'b1;
                        state_next = S_DRAIN;
                    end else begin
                        pad_cnt_next = pad_cnt + PAD_W'(1);
                    end
                end else begin
                    data_sh_next = data_shifted;
                    bit_cnt_next = BIT_W'(1);
                    state_next   = S_DATA;
                end
            end

            S_DATA: begin
                if (valid_n) begin
                    proto_det  = 1'b1;
                    state_next = S_DRAIN;
                end else if (bit_cnt != LAST_BIT) begin
                    if (frame_n) begin
                        proto_det  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        data_sh_next = data_shifted;
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end else if (frame_n) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    proto_det  = 1'b1;
                    state_next = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (frame_n && valid_n) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            addr_cnt <= '0;
            pad_cnt  <= '0;
            bit_cnt  <= '0;
            da_sh    <= '0;
            data_sh  <= '0;
        end else begin
            state    <= state_next;
            addr_cnt <= addr_cnt_next;
            pad_cnt  <= pad_cnt_next;
            bit_cnt  <= bit_cnt_next;
            da_sh    <= da_sh_next;
            data_sh  <= data_sh_next;
        end
    end

    // A pop on the completion edge frees the slot in time for the new packet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_valid <= 1'b0;
            pkt_da    <= '0;
            pkt_data  <= '0;
            pkt_cnt   <= '0;
            err_proto <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            err_proto <= proto_det;
            err_drop  <= 1'b0;
            if (complete) begin
                if (!pkt_valid || pkt_ready) begin
                    pkt_valid <= 1'b1;
                    pkt_da    <= da_sh;
                    pkt_data  <= assembled;
                    pkt_cnt   <= pkt_cnt + 8'd1;
                end else begin
                    err_drop <= 1'b1;
                end
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

endmodule
